// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data memory bus arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_BUSY = 2'd1,
    D_BUSY = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } arb_owner_e;

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;

endpackage

// File: rtl/mem_arb_watchdog.sv
// Ack-timeout counter: counts enabled cycles since the last clear and
// flags the TIMEOUT-th one so the arbiter can abort on that edge.
module mem_arb_watchdog #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expire_c
);

  localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  logic [CW-1:0] r_count;

  // r_count holds the number of busy cycles already elapsed
  assign o_expire_c = i_enable && (r_count == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && !o_expire_c) begin
      r_count <= r_count + CW'(1);
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one memory bus between the fetch and data ports with data priority,
// a fetch starvation guard and an ack watchdog. Optional ARB_PERF_CNT_EN adds
// grant/wait performance counters.
module mem_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned AW         = 32,
  parameter int unsigned DW         = 32,
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic [DW-1:0] i_rdata,
  output logic          i_ack,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [1:0]    d_size,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_ack,
  output logic          mem_req,
  output logic          mem_we,
  output logic [1:0]    mem_size,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack_n,
  output logic          timeout_err,
  output logic [31:0]   perf_igrant,
  output logic [31:0]   perf_dgrant,
  output logic [31:0]   perf_wait
);

  localparam int unsigned SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  arb_state_e    r_state;
  logic [SW-1:0] r_starve;
  logic          r_mem_req;
  logic          r_mem_we;
  logic [1:0]    r_mem_size;
  logic [AW-1:0] r_mem_addr;
  logic [DW-1:0] r_mem_wdata;
  logic          r_i_ack;
  logic          r_d_ack;
  logic [DW-1:0] r_i_rdata;
  logic [DW-1:0] r_d_rdata;
  logic          r_timeout_err;

  logic       w_busy;
  logic       w_ack;
  logic       w_expire;
  logic       w_done;
  logic       w_arb;
  logic       w_starved;
  logic       w_grant_i;
  logic       w_grant_d;
  arb_owner_e w_owner;

  // A real ack on the expiry cycle completes normally rather than aborting
  always_comb begin
    w_busy    = (r_state != IDLE);
    w_ack     = w_busy && !mem_ack_n;
    w_done    = w_ack || w_expire;
    w_arb     = !w_busy || w_done;
    w_starved = (r_starve == SW'(STARVE_MAX));
    w_grant_i = w_arb && i_req && (!d_req || w_starved);
    w_grant_d = w_arb && d_req && !w_grant_i;
    w_owner   = (r_state == D_BUSY) ? OWN_D : OWN_I;
  end

  mem_arb_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk        (clk),
    .rst        (rst),
    .i_clear    (w_arb),
    .i_enable   (w_busy),
    .o_expire_c (w_expire)
  );

  // Completion and the next grant share one edge for back-to-back transfers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= IDLE;
      r_starve      <= '0;
      r_mem_req     <= 1'b0;
      r_mem_we      <= 1'b0;
      r_mem_size    <= SZ_WORD;
      r_mem_addr    <= '0;
      r_mem_wdata   <= '0;
      r_i_ack       <= 1'b0;
      r_d_ack       <= 1'b0;
      r_i_rdata     <= '0;
      r_d_rdata     <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_i_ack <= 1'b0;
      r_d_ack <= 1'b0;

      if (w_done) begin
        if (w_owner == OWN_I) begin
          r_i_ack   <= 1'b1;
          r_i_rdata <= w_ack ? mem_rdata : '0;
        end else begin
          r_d_ack   <= 1'b1;
          r_d_rdata <= w_ack ? mem_rdata : '0;
        end
        if (!w_ack) begin
          r_timeout_err <= 1'b1;
        end
      end

      if (w_grant_i) begin
        r_state     <= I_BUSY;
        r_starve    <= '0;
        r_mem_req   <= 1'b1;
        r_mem_we    <= 1'b0;
        r_mem_size  <= SZ_WORD;
        r_mem_addr  <= i_addr;
        r_mem_wdata <= '0;
      end else if (w_grant_d) begin
        r_state     <= D_BUSY;
        r_mem_req   <= 1'b1;
        r_mem_we    <= d_we;
        r_mem_size  <= d_size;
        r_mem_addr  <= d_addr;
        r_mem_wdata <= d_wdata;
        // Data only beats a pending fetch while below the limit, so this saturates
        if (i_req) begin
          r_starve <= r_starve + SW'(1);
        end
      end else if (w_done) begin
        r_state   <= IDLE;
        r_mem_req <= 1'b0;
      end
    end
  end

  assign mem_req     = r_mem_req;
  assign mem_we      = r_mem_we;
  assign mem_size    = r_mem_size;
  assign mem_addr    = r_mem_addr;
  assign mem_wdata   = r_mem_wdata;
  assign i_ack       = r_i_ack;
  assign d_ack       = r_d_ack;
  assign i_rdata     = r_i_rdata;
  assign d_rdata     = r_d_rdata;
  assign timeout_err = r_timeout_err;

`ifdef ARB_PERF_CNT_EN
  logic [31:0] r_perf_igrant;
  logic [31:0] r_perf_dgrant;
  logic [31:0] r_perf_wait;

  // Wait counts cycles with a request pending but no completion pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_perf_igrant <= '0;
      r_perf_dgrant <= '0;
      r_perf_wait   <= '0;
    end else begin
      if (w_grant_i) begin
        r_perf_igrant <= r_perf_igrant + 32'd1;
      end
      if (w_grant_d) begin
        r_perf_dgrant <= r_perf_dgrant + 32'd1;
      end
      if ((i_req || d_req) && !(r_i_ack || r_d_ack)) begin
        r_perf_wait <= r_perf_wait + 32'd1;
      end
    end
  end

  assign perf_igrant = r_perf_igrant;
  assign perf_dgrant = r_perf_dgrant;
  assign perf_wait   = r_perf_wait;
`else
  assign perf_igrant = '0;
  assign perf_dgrant = '0;
  assign perf_wait   = '0;
`endif

endmodule
